serial_sub_decoder: RTL
=======================

# serial_sub_decoder

Bit-serial subtractor that recovers operand x from a serial sum stream s = x + y, where y is presented serially in parallel with s. It is the receive-side counterpart of the bit-serial adder datapath. The block consumes one LSB-first word of WIDTH bits, emits each recovered difference bit serially, and presents the assembled word with the final borrow and a one-cycle valid pulse.

## Interface
- WIDTH, 8, word length in bits; legal range is 2 to 32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  marks the cycle that carries bit 0 (LSB) of a new word.
- s  input  1  serial sum bit, LSB first.
- y  input  1  serial operand bit, aligned with s.
- busy  output  1  high while bits 1..WIDTH-1 of a word are expected.
- x_bit  output  1  registered serial difference bit.
- x_word  output  WIDTH  last completed recovered word.
- borrow_out  output  1  final borrow of the last completed word; 1 means s < y, i.e. x wrapped.
- valid  output  1  one-cycle pulse when x_word and borrow_out update.

## Operation
- States:
  - IDLE: waits for start. s and y are ignored unless start is high.
  - SHIFT: consumes bits 1..WIDTH-1.
- Per consumed bit:
  - d = s ^ y ^ b.
  - b_next = (~s & y) | (~(s ^ y) & b).
  - b is forced to 0 on a start cycle.
- Shift register sh[WIDTH-1:0] receives d at the MSB and shifts right each consumed bit. After WIDTH bits, sh holds x.
- Bit counter cnt runs 0..WIDTH-1. cnt is 0 on a start cycle and increments per consumed bit.
- Transitions:
  - IDLE + start: consume bit 0, then go to SHIFT with cnt = 1.
  - SHIFT, cnt < WIDTH-1: consume bit, increment cnt.
  - SHIFT, cnt == WIDTH-1, no start: consume the last bit. Load x_word with the final shifted value and borrow_out with b_next. Pulse valid. Return to IDLE.
- start asserted while in SHIFT, including on the last-bit cycle:
  - The current word is aborted: no valid, and x_word/borrow_out are unchanged.
  - The cycle is treated as bit 0 of a new word.
  - State stays SHIFT with cnt = 1.
- x_bit is updated with d on every consumed bit. It holds its value otherwise.
- Arithmetic is modulo 2^WIDTH. The borrow is exposed only through borrow_out and never extends x_word.
- Reset values: state IDLE, cnt 0, b 0, sh 0, busy 0, x_bit 0, x_word 0, borrow_out 0, valid 0.
- Reset asserted mid-word discards the word; no valid is produced.

## Timing
- Word with start in cycle T:
  - Bit k is sampled in cycle T+k.
  - x_bit for bit k is visible in cycle T+k+1.
- busy is high in cycles T+1 .. T+WIDTH-1 and low in cycle T+WIDTH.
- valid is high in cycle T+WIDTH only. x_word and borrow_out change in that same cycle and hold until the next valid.
- Latency from the last input bit to valid is 1 cycle.
- Back-to-back words: the next start is legal in cycle T+WIDTH, coinciding with valid. That gives zero idle cycles and full throughput of one word per WIDTH cycles.
- A start in cycle T+WIDTH-1 aborts the word (abort rule above).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- WIDTH=8, s=0x5A, y=0x23, start at T → valid at T+8, x_word=0x37, borrow_out=0. x_bit sequence (LSB first) in cycles T+1..T+8 is 1,1,1,0,1,1,0,0.
- WIDTH=8, s=0x10, y=0x20 → x_word=0xF0, borrow_out=1. Then s=0xFF, y=0x00 back-to-back (start at T+8) → valid at T+16, x_word=0xFF, borrow_out=0, with no gap cycles.
- WIDTH=8, word started at T; start re-asserted at T+4 with s=0x03, y=0x01 → no valid at T+8, valid at T+12, x_word=0x02.
- WIDTH=8, rst_n pulsed low at T+3 mid-word → all outputs 0 immediately (asynchronous). No valid follows. The next word, s=0x01, y=0x01, gives x_word=0x00, borrow_out=0.
- Random WIDTH=8 and WIDTH=32 words (1000 each) against a reference model of x = (s - y) mod 2^WIDTH → x_word and borrow_out match. busy and valid timing are checked every word.
- Idle stimulus: s and y toggling with start low for 20 cycles → x_bit, x_word and valid unchanged, busy stays 0.

Source files
------------

// File: rtl/serial_sub_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub_decoder_if
// Brief    : Serial word stream in, recovered word/borrow/valid out.
// Revision : 1.0
// ============================================================================
interface serial_sub_decoder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             s;
    logic             y;
    logic             busy;
    logic             x_bit;
    logic [WIDTH-1:0] x_word;
    logic             borrow_out;
    logic             valid;

    modport master (
        output start, s, y,
        input  busy, x_bit, x_word, borrow_out, valid
    );

    modport slave (
        input  start, s, y,
        output busy, x_bit, x_word, borrow_out, valid
    );
endinterface
`default_nettype wire

// File: rtl/serial_sub_decoder.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub_decoder
// Brief    : Bit-serial subtractor recovering x = s - y (mod 2^WIDTH), LSB first.
// Revision : 1.0
// ============================================================================
module serial_sub_decoder #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_sub_decoder_if.slave  bus
);
    localparam int               CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             b;
    logic [WIDTH-1:0] sh;
    logic             busy_r;
    logic             x_bit_r;
    logic [WIDTH-1:0] x_word_r;
    logic             borrow_r;
    logic             valid_r;

    logic             consume;
    logic             b_in;
    logic             d;
    logic             b_next;
    logic [WIDTH-1:0] sh_next;

    // A start cycle is always bit 0 of a fresh word, so the incoming borrow is cleared.
    assign consume = bus.start || (state == SHIFT);
    assign b_in    = bus.start ? 1'b0 : b;
    assign d       = bus.s ^ bus.y ^ b_in;
    assign b_next  = (~bus.s & bus.y) | (~(bus.s ^ bus.y) & b_in);
    assign sh_next = {d, sh[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            b        <= 1'b0;
            sh       <= '0;
            busy_r   <= 1'b0;
            x_bit_r  <= 1'b0;
            x_word_r <= '0;
            borrow_r <= 1'b0;
            valid_r  <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (consume) begin
                x_bit_r <= d;
                sh      <= sh_next;
                b       <= b_next;
            end
            if (bus.start) begin
                // Also covers an abort: the partial word is simply dropped.
                state  <= SHIFT;
                cnt    <= CNT_W'(1);
                busy_r <= 1'b1;
            end else if (state == SHIFT) begin
                if (cnt == LAST) begin
                    state    <= IDLE;
                    cnt      <= '0;
                    busy_r   <= 1'b0;
                    x_word_r <= sh_next;
                    borrow_r <= b_next;
                    valid_r  <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.busy       = busy_r;
    assign bus.x_bit      = x_bit_r;
    assign bus.x_word     = x_word_r;
    assign bus.borrow_out = borrow_r;
    assign bus.valid      = valid_r;
endmodule
`default_nettype wire
